// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-port memory between the cpu (C) and a debug loader (D).
// One access at a time: IDLE samples requests, ISSUE drives MEM for one cycle, RDWAIT captures read data.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic [1:0]    c_cmd,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic [1:0]    d_cmd,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          d_lock,
    output logic [1:0]    m_cmd,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT} state_e;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;   // 1 = D was granted last
    logic          win_d_q, win_d_d;             // 1 = access in flight belongs to D
    logic          is_read_q, is_read_d;
    logic [1:0]    m_cmd_q, m_cmd_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          c_ack_q, c_ack_d, d_ack_q, d_ack_d;
    logic          c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic [1:0]    owner_q, owner_d;

    logic          elig_c, elig_d, pick_d, grant;
    logic [1:0]    sel_cmd;

    assign elig_c  = c_req & ~d_lock;
    assign elig_d  = d_req;
    assign grant   = elig_c | elig_d;
    // On a tie the port that did not win last time gets the memory.
    assign pick_d  = elig_d & (~elig_c | ~last_grant_q);
    assign sel_cmd = pick_d ? d_cmd : c_cmd;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d_d      = win_d_q;
        is_read_d    = is_read_q;
        m_cmd_d      = CMD_NONE;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        c_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        c_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
        owner_d      = owner_q;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    // Commands 00 and 11 are acknowledged but never reach MEM.
                    m_cmd_d      = (sel_cmd == CMD_READ || sel_cmd == CMD_WRITE) ? sel_cmd : CMD_NONE;
                    m_addr_d     = pick_d ? d_addr  : c_addr;
                    m_wdata_d    = pick_d ? d_wdata : c_wdata;
                    last_grant_d = pick_d;
                    win_d_d      = pick_d;
                    is_read_d    = (sel_cmd == CMD_READ);
                    c_ack_d      = ~pick_d;
                    d_ack_d      = pick_d;
                    owner_d      = pick_d ? 2'b10 : 2'b01;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_read_q) begin
                    state_d = S_RDWAIT;
                end else begin
                    owner_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (win_d_q) begin
                    d_rdata_d  = m_rdata;
                    d_rvalid_d = 1'b1;
                end else begin
                    c_rdata_d  = m_rdata;
                    c_rvalid_d = 1'b1;
                end
                owner_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                owner_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            win_d_q      <= 1'b0;
            is_read_q    <= 1'b0;
            m_cmd_q      <= CMD_NONE;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            c_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            c_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
            owner_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_d_q      <= win_d_d;
            is_read_q    <= is_read_d;
            m_cmd_q      <= m_cmd_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            c_ack_q      <= c_ack_d;
            d_ack_q      <= d_ack_d;
            c_rvalid_q   <= c_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
            owner_q      <= owner_d;
        end
    end

    assign c_ack    = c_ack_q;
    assign d_ack    = d_ack_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_cmd    = m_cmd_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read single-port memory model behind it.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, d_req, d_lock;
    logic [1:0]    c_cmd, d_cmd;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_ack, c_rvalid, d_ack, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic [1:0]    m_cmd, owner;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    logic [DW-1:0] mem [2**AW];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_cmd(c_cmd), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_lock(d_lock),
        .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .owner(owner)
    );

    // Memory: read data appears the cycle after m_cmd=01; pl_* lets the bench preload words.
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (m_cmd == 2'b01)
            m_rdata <= mem[m_addr];
        else if (m_cmd == 2'b10)
            mem[m_addr] <= m_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({c_ack, d_ack, c_rvalid, d_rvalid, m_cmd, owner} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {c_ack, d_ack, c_rvalid, d_rvalid, m_cmd, owner});
        end
        n_checks++;
        if ({c_rdata, d_rdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 00000000", {c_rdata, d_rdata});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_c_read();
        c_req = 1'b1; c_cmd = 2'b01; c_addr = 9'h005;
        tick();
        n_checks++;
        if ({c_ack, d_ack, m_cmd, m_addr, owner} !== {1'b1, 1'b0, 2'b01, 9'h005, 2'b01}) begin
            n_fail++;
            $display("FAIL c_read_issue: ack c/d=%b%b m_cmd=%b m_addr=%h owner=%b expected 10 01 005 01",
                     c_ack, d_ack, m_cmd, m_addr, owner);
        end
        c_req = 1'b0;
        tick();
        n_checks++;
        if ({c_ack, m_cmd, c_rvalid, d_ack, d_rvalid} !== 6'b0_00_000) begin
            n_fail++;
            $display("FAIL c_read_wait: got %b expected 000000", {c_ack, m_cmd, c_rvalid, d_ack, d_rvalid});
        end
        tick();
        n_checks++;
        if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, 16'hABCD}) begin
            n_fail++;
            $display("FAIL c_read_data: rvalid c/d=%b%b rdata=%h expected 10 abcd", c_rvalid, d_rvalid, c_rdata);
        end
        tick();
        n_checks++;
        if (c_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL c_rvalid_pulse: got %b expected 0", c_rvalid);
        end
    endtask

    task automatic test_simul_writes();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        c_req = 1'b1; c_cmd = 2'b10; c_addr = 9'h010; c_wdata = 16'h1234;
        d_req = 1'b1; d_cmd = 2'b10; d_addr = 9'h011; d_wdata = 16'h5678;
        tick();
        n_checks++;
        if ({c_ack, d_ack, owner, m_cmd, m_addr, m_wdata} !== {2'b10, 2'b01, 2'b10, 9'h010, 16'h1234}) begin
            n_fail++;
            $display("FAIL wr_first_c: ack=%b%b owner=%b m=%b/%h/%h expected 10 01 10/010/1234",
                     c_ack, d_ack, owner, m_cmd, m_addr, m_wdata);
        end
        c_req = 1'b0;
        tick();
        n_checks++;
        if ({c_ack, d_ack, owner, m_cmd} !== 6'b0) begin
            n_fail++;
            $display("FAIL wr_gap: got %b expected 000000", {c_ack, d_ack, owner, m_cmd});
        end
        tick();
        n_checks++;
        if ({c_ack, d_ack, owner, m_cmd, m_addr, m_wdata} !== {2'b01, 2'b10, 2'b10, 9'h011, 16'h5678}) begin
            n_fail++;
            $display("FAIL wr_second_d: ack=%b%b owner=%b m=%b/%h/%h expected 01 10 10/011/5678",
                     c_ack, d_ack, owner, m_cmd, m_addr, m_wdata);
        end
        d_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem[9'h010], mem[9'h011]} !== {16'h1234, 16'h5678}) begin
            n_fail++;
            $display("FAIL wr_mem: got %h %h expected 1234 5678", mem[9'h010], mem[9'h011]);
        end
    endtask

    task automatic test_back_to_back();
        c_req = 1'b1; c_cmd = 2'b01; c_addr = 9'h020;
        d_req = 1'b1; d_cmd = 2'b01; d_addr = 9'h021;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_checks++;
            if ({c_ack, d_ack, c_rvalid, d_rvalid} !==
                {(i % 6 == 1), (i % 6 == 4), (i % 6 == 3), (i % 6 == 0)}) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: ack c/d rvalid c/d=%b%b%b%b expected %b%b%b%b", i,
                         c_ack, d_ack, c_rvalid, d_rvalid,
                         (i % 6 == 1), (i % 6 == 4), (i % 6 == 3), (i % 6 == 0));
            end
            if (i % 6 == 3) begin
                n_checks++;
                if (c_rdata !== 16'hAAAA) begin
                    n_fail++;
                    $display("FAIL rr_c_data%0d: got %h expected aaaa", i, c_rdata);
                end
            end
            if (i % 6 == 0) begin
                n_checks++;
                if (d_rdata !== 16'h5555) begin
                    n_fail++;
                    $display("FAIL rr_d_data%0d: got %h expected 5555", i, d_rdata);
                end
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_lock();
        d_lock = 1'b1;
        c_req = 1'b1; c_cmd = 2'b10; c_addr = 9'h031; c_wdata = 16'hC0DE;
        d_req = 1'b1; d_cmd = 2'b10; d_addr = 9'h030; d_wdata = 16'h0D0D;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({c_ack, d_ack} !== {1'b0, (i % 2 == 1)}) begin
                n_fail++;
                $display("FAIL lock_cycle%0d: ack c/d=%b%b expected 0%b", i, c_ack, d_ack, (i % 2 == 1));
            end
        end
        d_lock = 1'b0; d_req = 1'b0;
        tick();
        n_checks++;
        if ({c_ack, d_ack, owner} !== 4'b1001) begin
            n_fail++;
            $display("FAIL unlock_c_grant: ack=%b%b owner=%b expected 10 01", c_ack, d_ack, owner);
        end
        c_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem[9'h030], mem[9'h031]} !== {16'h0D0D, 16'hC0DE}) begin
            n_fail++;
            $display("FAIL lock_mem: got %h %h expected 0d0d c0de", mem[9'h030], mem[9'h031]);
        end
    endtask

    task automatic test_reset_midread();
        c_req = 1'b1; c_cmd = 2'b01; c_addr = 9'h005;
        tick();
        c_req = 1'b0;
        tick();
        n_checks++;
        if (owner !== 2'b01) begin
            n_fail++;
            $display("FAIL rdwait_owner: got %b expected 01", owner);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({m_cmd, owner} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: m_cmd/owner=%b expected 0000", {m_cmd, owner});
        end
        tick();
        n_checks++;
        if ({c_rvalid, c_rdata} !== 17'h0) begin
            n_fail++;
            $display("FAIL abandoned_read: rvalid=%b rdata=%h expected 0 0000", c_rvalid, c_rdata);
        end
        reset = 1'b1;
        tick();
        c_req = 1'b1; c_cmd = 2'b01; c_addr = 9'h040;
        tick();
        n_checks++;
        if ({c_ack, m_cmd, m_addr} !== {1'b1, 2'b01, 9'h040}) begin
            n_fail++;
            $display("FAIL fresh_issue: ack=%b m_cmd=%b m_addr=%h expected 1 01 040", c_ack, m_cmd, m_addr);
        end
        c_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({c_rvalid, c_rdata} !== {1'b1, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL fresh_data: rvalid=%b rdata=%h expected 1 beef", c_rvalid, c_rdata);
        end
        tick();
    endtask

    task automatic test_null_cmd();
        logic [1:0] cmds [2];
        cmds[0] = 2'b00;
        cmds[1] = 2'b11;
        for (int k = 0; k < 2; k++) begin
            d_req = 1'b1; d_cmd = cmds[k]; d_addr = 9'h050; d_wdata = 16'h1111;
            tick();
            n_checks++;
            if ({d_ack, m_cmd, owner} !== 5'b1_00_10) begin
                n_fail++;
                $display("FAIL null_issue_cmd%b: ack=%b m_cmd=%b owner=%b expected 1 00 10",
                         cmds[k], d_ack, m_cmd, owner);
            end
            d_req = 1'b0;
            tick();
            n_checks++;
            if ({d_ack, d_rvalid, m_cmd, owner} !== 6'b0) begin
                n_fail++;
                $display("FAIL null_after_cmd%b: got %b expected 000000", cmds[k], {d_ack, d_rvalid, m_cmd, owner});
            end
            tick();
            n_checks++;
            if (d_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL null_rvalid_cmd%b: got %b expected 0", cmds[k], d_rvalid);
            end
        end
        n_checks++;
        if (mem[9'h050] !== 16'h7777) begin
            n_fail++;
            $display("FAIL null_mem: got %h expected 7777", mem[9'h050]);
        end
    endtask

    initial begin
        reset = 1'b0;
        c_req = 1'b0; c_cmd = 2'b00; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_cmd = 2'b00; d_addr = '0; d_wdata = '0;
        d_lock = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #1;
        preload(9'h005, 16'hABCD);
        preload(9'h020, 16'hAAAA);
        preload(9'h021, 16'h5555);
        preload(9'h040, 16'hBEEF);
        preload(9'h050, 16'h7777);

        test_reset();
        test_c_read();
        test_simul_writes();
        test_back_to_back();
        test_lock();
        test_reset_midread();
        test_null_cmd();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
